// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline boundary: registers the execute result and presents it to the memory-access stage.
// Latency: 1 cycle from acceptance to mem_* when draining; sustains 1 result/cycle while mem_ready=1.
// Backpressure: 2-entry skid (main + skid); ex_ready comes from a flop and drops only when both entries are full.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
    } ent_t;

    // State encoding doubles as the entry valid bits: bit0 = main valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    ent_t             main_q, main_d;
    ent_t             skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_xfer;
    logic out_xfer;
    ent_t cap;

    assign ex_ready   = ~state_q[1];
    assign mem_valid  = state_q[0];
    assign mem_wd     = main_q.wd;
    assign mem_wreg   = main_q.wreg;
    assign mem_wdata  = main_q.wdata;
    assign retire_cnt = cnt_q;

    assign in_xfer  = ex_valid & ex_ready;
    assign out_xfer = mem_valid & mem_ready;

    // Incoming result as it will be stored; a write-disabled result carries no data.
    always_comb begin
        cap       = '0;
        cap.wd    = ex_wd;
        cap.wreg  = ex_wreg;
        cap.wdata = ex_wreg ? ex_wdata : '0;
    end

    // Next-state for the two entries; an emptied main entry is zeroed so bubbles read as NOP.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    main_d  = cap;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = cap;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = cap;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                    main_d  = '0;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        // Flush wins over everything: buffered and incoming results are discarded.
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    // Retire counter advances on every consumed result, including one consumed in a flush cycle.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(out_xfer);
    end

    // State, entries and counter registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_mem_skid.sv
module tb_ex_mem_skid;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [AW-1:0] ex_wd;
    logic          ex_wreg;
    logic [DW-1:0] ex_wdata;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_wd;
    logic          mem_wreg;
    logic [DW-1:0] mem_wdata;
    logic [CW-1:0] retire_cnt;

    ex_mem_skid #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] wdata;
    } ent_t;

    // Scoreboard: results held inside the DUT, oldest first.
    ent_t          sb[$];
    logic [CW-1:0] cnt_m;
    int            checks;
    int            failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        ent_t e;
        e = (sb.size() > 0) ? sb[0] : '0;
        chk("mem_valid", 64'(mem_valid), 64'(sb.size() > 0));
        chk("ex_ready", 64'(ex_ready), 64'(sb.size() < 2));
        chk("mem_wd", 64'(mem_wd), 64'(e.wd));
        chk("mem_wreg", 64'(mem_wreg), 64'(e.wreg));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        chk("retire_cnt", 64'(retire_cnt), 64'(cnt_m));
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] wd, input logic wr,
                         input logic [DW-1:0] wdat, input logic mr, input logic fl);
        ex_valid  = v;
        ex_wd     = wd;
        ex_wreg   = wr;
        ex_wdata  = wdat;
        mem_ready = mr;
        flush     = fl;
    endtask

    // One clock: predict transfers from the model, advance, then compare.
    task automatic step();
        bit   in_x;
        bit   out_x;
        bit   fl;
        ent_t c;
        in_x    = ex_valid && (sb.size() < 2);
        out_x   = mem_ready && (sb.size() > 0);
        fl      = flush;
        c.wd    = ex_wd;
        c.wreg  = ex_wreg;
        c.wdata = ex_wreg ? ex_wdata : '0;
        @(posedge clk);
        #1;
        if (out_x) begin
            void'(sb.pop_front());
            cnt_m++;
        end
        if (fl) sb.delete();
        else if (in_x) sb.push_back(c);
        check_state();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cnt_m    = '0;
        rst      = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state();
        rst = 1'b1;
        step();

        // Streaming, back-to-back with mem_ready=1
        drive(1'b1, 5'd3, 1'b1, 32'h0000_1234, 1'b1, 1'b0); step();
        drive(1'b1, 5'd4, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0); step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);         step();
        chk("stream_cnt", 64'(retire_cnt), 64'd2);

        // Stall fill: A, B accepted, C refused, then drain
        drive(1'b1, 5'd1, 1'b1, 32'hA, 1'b0, 1'b0); step();
        drive(1'b1, 5'd2, 1'b1, 32'hB, 1'b0, 1'b0); step();
        chk("full_ex_ready", 64'(ex_ready), 64'd0);
        drive(1'b1, 5'd9, 1'b1, 32'hC, 1'b0, 1'b0); step();
        chk("stall_hold_A", 64'(mem_wdata), 64'hA);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0); step();
        chk("drain_B", 64'(mem_wdata), 64'hB);
        step();
        step();

        // Write-disable zeroing
        drive(1'b1, 5'd7, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0); step();
        chk("wdis_wd", 64'(mem_wd), 64'd7);
        chk("wdis_wdata", 64'(mem_wdata), 64'd0);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0); step();

        // Flush while FULL with ex_valid=1, no out_xfer
        drive(1'b1, 5'd10, 1'b1, 32'h10, 1'b0, 1'b0); step();
        drive(1'b1, 5'd11, 1'b1, 32'h11, 1'b0, 1'b0); step();
        drive(1'b1, 5'd12, 1'b1, 32'h55, 1'b0, 1'b1); step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);   step();

        // Flush while FULL with out_xfer: counter still advances once
        drive(1'b1, 5'd10, 1'b1, 32'h20, 1'b0, 1'b0); step();
        drive(1'b1, 5'd11, 1'b1, 32'h21, 1'b0, 1'b0); step();
        drive(1'b1, 5'd13, 1'b1, 32'h66, 1'b1, 1'b1); step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);   step();

        // Flush while BUSY: the accepted-looking input is dropped
        drive(1'b1, 5'd15, 1'b1, 32'h30, 1'b0, 1'b0); step();
        drive(1'b1, 5'd14, 1'b1, 32'h77, 1'b0, 1'b1); step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);   step();

        // Async reset mid-stall, between clock edges
        drive(1'b1, 5'd5, 1'b1, 32'h40, 1'b0, 1'b0); step();
        drive(1'b1, 5'd6, 1'b1, 32'h41, 1'b0, 1'b0); step();
        #3;
        rst = 1'b0;
        #1;
        chk("arst_mem_valid", 64'(mem_valid), 64'd0);
        chk("arst_retire_cnt", 64'(retire_cnt), 64'd0);
        chk("arst_ex_ready", 64'(ex_ready), 64'd1);
        chk("arst_mem_wdata", 64'(mem_wdata), 64'd0);
        sb.delete();
        cnt_m = '0;
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        step();

        // Counter wrap: 17 transfers on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'(i), 1'b1, $urandom, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("retire_wrap", 64'(retire_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
